// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a shared-decoder
// multi-digit 7-segment display, with dead time and frame-atomic updates.
//
// Ports:
//   clk, rst_n  clock (rising edge), async active-low reset
//   en          scan enable; 0 forces the display dark
//   load        1-cycle strobe capturing bcd_in ([3:0] = digit 0)
//   lz_blank    suppress leading zeros
//   bcd_out     BCD code to the shared decoder (4'hF when idle)
//   digit_en    one-hot active-high digit enables
//   frame_done  1-cycle pulse after the last digit's dwell
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nx;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nx;
  logic [DW-1:0]         shadow;
  logic [DW-1:0]         shadow_nx;
  logic [DW-1:0]         active;
  logic [DW-1:0]         active_nx;
  logic                  pending;
  logic                  pending_nx;
  logic                  wrap;
  logic                  zero_hi;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            bcd_nx;
  logic [NUM_DIGITS-1:0] den_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      bcd_out    <= 4'hF;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      shadow     <= shadow_nx;
      active     <= active_nx;
      pending    <= pending_nx;
      bcd_out    <= bcd_nx;
      digit_en   <= den_nx;
      frame_done <= wrap;
    end
  end

  // Sequencing: wrap marks the edge closing the last digit's dwell.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    wrap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          state_nx = BLANK;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DRIVE: begin
        if (cnt == DWELL_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          if (idx == IDX_LAST) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
        cnt_nx   = '0;
      end
    endcase
    if (!en) begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
      wrap     = 1'b0;
    end
  end

  // Data path: a load on the wrap edge bypasses the shadow so the
  // newest value is what the starting frame shows.
  always_comb begin
    shadow_nx  = shadow;
    active_nx  = active;
    pending_nx = pending;
    if (wrap && pending) begin
      active_nx  = shadow;
      pending_nx = 1'b0;
    end
    if (load) begin
      shadow_nx  = bcd_in;
      pending_nx = 1'b1;
      if (state == IDLE || wrap) begin
        active_nx = bcd_in;
      end
      if (wrap) begin
        pending_nx = 1'b0;
      end
    end
  end

  // Digit i>0 is a leading zero when it and every higher digit are 0.
  always_comb begin
    zero_hi = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_hi    = zero_hi & (active_nx[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_hi & (i != 0);
    end
  end

  always_comb begin
    bcd_nx = 4'hF;
    den_nx = '0;
    unique case (state_nx)
      BLANK: begin
        bcd_nx = active_nx[4*idx_nx +: 4];
      end
      DRIVE: begin
        bcd_nx = active_nx[4*idx_nx +: 4];
        if (!(lz_blank && lz_mask[idx_nx])) begin
          den_nx = NUM_DIGITS'(1) << idx_nx;
        end
      end
      default: begin
        bcd_nx = 4'hF;
        den_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed bench for seg_scan_ctrl
// against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int D = 4;
  localparam int B = 2;
  localparam int S = B + D;
  localparam int P = N * S;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [4*N-1:0] bcd_in;
  logic          lz_blank;
  logic [3:0]    bcd_out;
  logic [N-1:0]  digit_en;
  logic          frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .bcd_in    (bcd_in),
    .lz_blank  (lz_blank),
    .bcd_out   (bcd_out),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: position t within the frame, 0 = first blank cycle.
  bit             running;
  int             t;
  logic [4*N-1:0] act;
  logic [4*N-1:0] shd;
  bit             pend;
  logic [3:0]     exp_bcd;
  logic [N-1:0]   exp_den;
  logic           exp_fd;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    running = 0;
    t       = 0;
    act     = '0;
    shd     = '0;
    pend    = 0;
    exp_bcd = 4'hF;
    exp_den = '0;
    exp_fd  = 1'b0;
  endtask

  task automatic model_step();
    bit idle_now;
    bit bnd;
    int slot;
    int ph;
    logic [4*N-1:0] hi;
    idle_now = !running;
    bnd      = 0;
    exp_fd   = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en) begin
      running = 0;
    end else if (!running) begin
      running = 1;
      t       = 0;
    end else begin
      bnd    = ((t + 1) % P) == 0;
      t      = (t + 1) % P;
      exp_fd = bnd;
      if (bnd && pend) begin
        act  = shd;
        pend = 0;
      end
    end
    if (load) begin
      shd  = bcd_in;
      pend = 1;
      if (idle_now) act = bcd_in;
      if (bnd) begin
        act  = bcd_in;
        pend = 0;
      end
    end
    if (!running) begin
      exp_bcd = 4'hF;
      exp_den = '0;
    end else begin
      slot    = t / S;
      ph      = t % S;
      exp_bcd = act[slot*4 +: 4];
      hi      = act >> (4 * slot);
      exp_den = '0;
      if (ph >= B && !(lz_blank && slot > 0 && hi == '0))
        exp_den = N'(1) << slot;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    chk("digit_en", 32'(digit_en), 32'(exp_den));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic bit at_point(int m);
    case (m)
      0: return running && (t / S == 2) && (t % S >= B);
      1: return running && (t == P - 1);
      2: return exp_fd == 1'b1;
      default: return running && (t % S >= B);
    endcase
  endfunction

  task automatic wait_pt(int m, string tag);
    bit found;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (at_point(m)) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic pulse_load(logic [4*N-1:0] v);
    load   = 1'b1;
    bcd_in = v;
    cycle();
    load   = 1'b0;
  endtask

  initial begin
    logic [15:0] masks [4];
    masks[0] = 16'hFFFF;
    masks[1] = 16'h00FF;
    masks[2] = 16'h000F;
    masks[3] = 16'h0F0F;

    rst_n    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    bcd_in   = '0;
    lz_blank = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bcd", 32'(bcd_out), 32'hF);
    chk("rst_den", 32'(digit_en), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    run(2);
    rst_n = 1'b1;

    // basic scan of 1234
    en = 1'b1;
    pulse_load(16'h1234);
    run(2 * P);

    // mid-frame load holds off until the frame boundary
    run(7);
    pulse_load(16'h5678);
    run(2 * P);

    // leading-zero blanking
    lz_blank = 1'b1;
    pulse_load(16'h0040);
    run(2 * P + 5);
    pulse_load(16'h0000);
    run(2 * P + 5);
    lz_blank = 1'b0;
    pulse_load(16'h1234);
    run(P + 3);

    // drop en mid-drive of digit 2, then restart
    wait_pt(0, "wait_drive2");
    en = 1'b0;
    cycle();
    chk("dark_bcd", 32'(bcd_out), 32'hF);
    run(2);
    en = 1'b1;
    run(P + 4);

    // load in the frame_done cycle
    wait_pt(2, "wait_fd");
    pulse_load(16'h9999);
    run(2 * P);

    // load in the boundary cycle goes straight to active
    wait_pt(1, "wait_bnd");
    pulse_load(16'h3333);
    run(P);

    // randomized traffic including codes 10..15
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom % 64) != 0;
      load   = ($urandom % 16) == 0;
      bcd_in = 16'($urandom) & masks[$urandom % 4];
      if ($urandom % 32 == 0) lz_blank = ~lz_blank;
      cycle();
    end
    load = 1'b0;
    en   = 1'b1;

    // async reset during a dwell
    wait_pt(3, "wait_dwell");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_bcd", 32'(bcd_out), 32'hF);
    chk("arst_den", 32'(digit_en), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    cycle();
    rst_n = 1'b1;
    pulse_load(16'h0807);
    run(P + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
